cic_interpolator: RTL and testbench

CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

---
 rtl/mso_cic_pkg.sv | 12 +
 rtl/cic_interp_stage.sv | 40 ++++
 rtl/cic_interpolator.sv | 122 ++++++++++++
 tb/tb_cic_interpolator.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mso_cic_pkg.sv
// Shared CIC constants and width helpers, used by both cic_interpolator and cic_decimator.
// Combinational only; no latency or backpressure.
package mso_cic_pkg;

   localparam int CIC_MAX_STAGES = 4;

   // Worst-case register growth for an M-stage interpolator by R on an in_w-bit input
   function automatic int cic_min_acc_width(input int r, input int m, input int in_w);
      return in_w + (m - 1) * $clog2(r);
   endfunction

endpackage

// File: rtl/cic_interp_stage.sv
// One CIC section: a low-rate comb delay (D=1) and a high-rate integrator, both ACC_WIDTH.
// Comb output is combinational; integrator output is registered. Frozen when i_en is low.
module cic_interp_stage
   import mso_cic_pkg::*;
#(
   parameter int ACC_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_en,
   input  logic                 i_slot,
   input  logic [ACC_WIDTH-1:0] i_comb_dat,
   output logic [ACC_WIDTH-1:0] o_comb_dat,
   input  logic [ACC_WIDTH-1:0] i_int_dat,
   output logic [ACC_WIDTH-1:0] o_int_dat
);

   logic [ACC_WIDTH-1:0] r_dly;
   logic [ACC_WIDTH-1:0] r_int;

   assign o_comb_dat = i_comb_dat - r_dly;
   assign o_int_dat  = r_int;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dly <= '0;
      end else if (i_slot) begin
         r_dly <= i_comb_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_int <= '0;
      end else if (i_en) begin
         r_int <= r_int + i_int_dat;
      end
   end

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator by R with M stages; y follows a taken sample by M enabled edges.
// Accepts one sample per R enabled cycles (x_ready); a missing sample repeats the last one.
// Optional sticky underrun flag: define CIC_INTERP_UNDERRUN_EN.
module cic_interpolator
   import mso_cic_pkg::*;
#(
   parameter int R            = 6,
   parameter int M            = 2,
   parameter int INPUT_WIDTH  = 16,
   parameter int OUTPUT_WIDTH = 12,
   parameter int ACC_WIDTH    = 24
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enabled,
   input  logic [INPUT_WIDTH-1:0]  x,
   input  logic                    x_valid,
   output logic                    x_ready,
   output logic [OUTPUT_WIDTH-1:0] y,
   output logic                    y_valid,
   output logic                    underrun
);

   localparam int P_W = (R > 1) ? $clog2(R) : 1;

   if (M < 1 || M > CIC_MAX_STAGES) begin : g_bad_order
      $error("cic_interpolator: M out of range");
   end
   if (R < 1 || R > 64) begin : g_bad_rate
      $error("cic_interpolator: R out of range");
   end
   if (ACC_WIDTH < cic_min_acc_width(R, M, INPUT_WIDTH) || OUTPUT_WIDTH > ACC_WIDTH) begin : g_bad_width
      $error("cic_interpolator: ACC_WIDTH too small for R, M, INPUT_WIDTH");
   end

   logic [P_W-1:0]       r_p;
   logic                 r_z;
   logic                 r_y_valid;
   logic [ACC_WIDTH-1:0] r_held;
   logic [ACC_WIDTH-1:0] r_c;
   logic                 w_slot;
   logic [ACC_WIDTH-1:0] w_x_ext;
   logic [ACC_WIDTH-1:0] w_u;
   logic [ACC_WIDTH-1:0] w_comb [0:M];
   logic [ACC_WIDTH-1:0] w_int  [0:M];

   assign w_slot     = enabled && (r_p == '0);
   assign x_ready    = w_slot;
   assign w_x_ext    = ACC_WIDTH'($signed(x));
   assign w_comb[0]  = x_valid ? w_x_ext : r_held;
   // Zero-stuffing: the comb result enters the integrators only on the cycle after a slot
   assign w_u        = (R == 1 || r_z) ? r_c : '0;
   assign w_int[0]   = w_u;
   assign y          = OUTPUT_WIDTH'(w_int[M] >> (ACC_WIDTH - OUTPUT_WIDTH));
   assign y_valid    = r_y_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p <= '0;
      end else if (enabled) begin
         r_p <= (r_p == P_W'(R - 1)) ? '0 : r_p + P_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_z    <= 1'b0;
         r_c    <= '0;
         r_held <= '0;
      end else begin
         if (enabled) begin
            r_z <= w_slot;
         end
         if (w_slot) begin
            r_c <= w_comb[M];
         end
         if (w_slot && x_valid) begin
            r_held <= w_x_ext;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y_valid <= 1'b0;
      end else begin
         r_y_valid <= enabled;
      end
   end

   for (genvar k = 1; k <= M; k++) begin : g_stage
      cic_interp_stage #(
         .ACC_WIDTH (ACC_WIDTH)
      ) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_en       (enabled),
         .i_slot     (w_slot),
         .i_comb_dat (w_comb[k-1]),
         .o_comb_dat (w_comb[k]),
         .i_int_dat  (w_int[k-1]),
         .o_int_dat  (w_int[k])
      );
   end

`ifdef CIC_INTERP_UNDERRUN_EN
   logic r_underrun;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_underrun <= 1'b0;
      end else if (w_slot && !x_valid) begin
         r_underrun <= 1'b1;
      end
   end

   assign underrun = r_underrun;
`else
   assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator (R=4, M=2): reference is the upsampled input convolved
// with M length-R boxcars, indexed by enabled edges.
module tb_cic_interpolator;

   localparam int R  = 4;
   localparam int M  = 2;
   localparam int IW = 12;
   localparam int AW = 16;
   localparam int OW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enabled;
   logic [IW-1:0] x;
   logic          x_valid;
   logic          x_ready;
   logic [OW-1:0] y;
   logic          y_valid;
   logic          underrun;

   cic_interpolator #(
      .R            (R),
      .M            (M),
      .INPUT_WIDTH  (IW),
      .OUTPUT_WIDTH (OW),
      .ACC_WIDTH    (AW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enabled  (enabled),
      .x        (x),
      .x_valid  (x_valid),
      .x_ready  (x_ready),
      .y        (y),
      .y_valid  (y_valid),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   int h[$];
   int s_hist[$];
   int ecnt;
   int held;
   bit und_m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic build_h();
      int nh[$];
      h = {1};
      for (int m = 0; m < M; m++) begin
         nh = {};
         for (int i = 0; i < h.size() + R - 1; i++) begin
            int acc = 0;
            for (int j = 0; j < R; j++) begin
               if (i - j >= 0 && i - j < h.size()) acc += h[i-j];
            end
            nh.push_back(acc);
         end
         h = nh;
      end
   endtask

   function automatic logic [OW-1:0] model_y();
      int sum = 0;
      int n = s_hist.size();
      for (int k = 0; k < h.size(); k++) begin
         int idx = n - 1 - M - k;
         if (idx >= 0) sum += h[k] * s_hist[idx];
      end
      return OW'(sum);
   endfunction

   function automatic logic exp_underrun();
`ifdef CIC_INTERP_UNDERRUN_EN
      return und_m;
`else
      return 1'b0;
`endif
   endfunction

   // Called at a negedge; returns at the next negedge
   task automatic cycle(input bit en, input bit xv, input int xd);
      bit slot;
      enabled = en;
      x_valid = xv;
      x       = xd[IW-1:0];
      #1;
      check("x_ready", x_ready, en && (ecnt % R == 0));
      @(posedge clk);
      if (en) begin
         slot = (ecnt % R == 0);
         if (slot) begin
            if (xv) held = int'($signed(x));
            else    und_m = 1'b1;
            s_hist.push_back(held);
         end else begin
            s_hist.push_back(0);
         end
         ecnt++;
      end
      #1;
      check("y", y, model_y());
      check("y_valid", y_valid, en);
      check("underrun", underrun, exp_underrun());
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      enabled = 1'b0;
      x_valid = 1'b0;
      #1;
      check("rst_y", y, 0);
      check("rst_x_ready", x_ready, 0);
      check("rst_y_valid", y_valid, 0);
      check("rst_underrun", underrun, 0);
      s_hist.delete();
      ecnt  = 0;
      held  = 0;
      und_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int imp_tab [8] = '{1, 2, 3, 4, 3, 2, 1, 0};
      bit dropped;
      x = '0;
      build_h();
      @(negedge clk);
      do_reset();

      // Impulse
      for (int i = 0; i < 16; i++) begin
         cycle(1, 1, (i == 0) ? 1 : 0);
         if (i >= M && i - M < 8) check("impulse_tab", y, imp_tab[i-M]);
         else if (i >= M + 8)     check("impulse_tail", y, 0);
      end

      // Step to 400
      do_reset();
      for (int i = 0; i < 20; i++) cycle(1, 1, 100);
      check("step_settle", y, 400);

      // Handshake with a 3-cycle enable gap mid-frame
      for (int i = 0; i < 6; i++)  cycle(1, 1, $urandom_range(0, 4095));
      for (int i = 0; i < 3; i++)  cycle(0, 1, $urandom_range(0, 4095));
      for (int i = 0; i < 10; i++) cycle(1, 1, $urandom_range(0, 4095));

      // Underrun: one missing slot at 50 steady state
      do_reset();
      for (int i = 0; i < 16; i++) cycle(1, 1, 50);
      check("steady_50", y, 200);
      dropped = 1'b0;
      for (int i = 0; i < 12; i++) begin
         bit miss = !dropped && (ecnt % R == 0);
         cycle(1, !miss, 50);
         if (miss) dropped = 1'b1;
      end
      check("underrun_hold_y", y, 200);
`ifdef CIC_INTERP_UNDERRUN_EN
      check("underrun_sticky", underrun, 1);
`else
      check("underrun_tied", underrun, 0);
`endif

      // Reset mid-frame at p=2 during a step, then the step repeats
      do_reset();
      for (int i = 0; i < 6; i++) cycle(1, 1, 100);
      check("phase_before_reset", ecnt % R, 2);
      do_reset();
      for (int i = 0; i < 20; i++) cycle(1, 1, 100);
      check("step_after_reset", y, 400);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 4095));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
